// File: rtl/cla_addsub_pipe.sv
// Three-stage pipelined carry-lookahead adder/subtractor.
//
// Stage 1 captures per-bit propagate/generate of a and the conditioned b operand.
// Stage 2 reduces 4-bit groups to group P/G and resolves every group carry-in.
// Stage 3 ripples inside each group from its carry-in, then registers the sum and flags.
// The whole pipe advances on one global enable, so a stalled output freezes every stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready = pipeline enable)
//   a, b, sub, c_in     operands; sub=1 gives a-b-c_in, sub=0 gives a+b+c_in
//   out_valid, out_ready  result handshake
//   s, c_out, ovf, zero registered sum, carry out (no-borrow for sub), signed overflow, s==0
module cla_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NGRP = WIDTH / GROUP;

  if (GROUP != 4 || (WIDTH % 4) != 0 || WIDTH < 8) begin : g_cfg_err
    $error("cla_addsub_pipe: GROUP must be 4 and WIDTH a multiple of 4, at least 8");
  end

  logic en;

  // Stage 1 state
  logic             v1_q;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic             c0_1_q, a_msb1_q, b_msb1_q;

  // Stage 2 state; cg2_q[NGRP] is the lookahead carry out of the top group
  logic             v2_q;
  logic [WIDTH-1:0] p2_q, g2_q;
  logic [NGRP:0]    cg2_q;
  logic             a_msb2_q, b_msb2_q;

  // Stage 3 (output) state
  logic             v3_q;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q, ovf_q, zero_q;

  // Combinational
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NGRP-1:0]  pg, gg;
  logic [NGRP:0]    cg;
  logic [WIDTH-1:0] sum;

  assign en       = out_ready | ~v3_q;
  assign in_ready = en;

  // Subtraction is a + ~b + 1 - borrow_in, so the carry seed is c_in inverted when sub=1.
  always_comb begin
    b_eff = b ^ {WIDTH{sub}};
    c0    = c_in ^ sub;
  end

  // Group propagate/generate and the cross-group carry lookahead.
  always_comb begin
    pg = '0;
    gg = '0;
    cg = '0;
    for (int k = 0; k < int'(NGRP); k++) begin
      pg[k] = &p1_q[k*GROUP +: GROUP];
      gg[k] = g1_q[k*GROUP+3]
            | (p1_q[k*GROUP+3] & g1_q[k*GROUP+2])
            | (p1_q[k*GROUP+3] & p1_q[k*GROUP+2] & g1_q[k*GROUP+1])
            | (p1_q[k*GROUP+3] & p1_q[k*GROUP+2] & p1_q[k*GROUP+1] & g1_q[k*GROUP]);
    end
    cg[0] = c0_1_q;
    for (int k = 0; k < int'(NGRP); k++) begin
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
    end
  end

  // Intra-group ripple seeded by each group's resolved carry-in.
  always_comb begin
    logic c;
    sum = '0;
    c   = 1'b0;
    for (int k = 0; k < int'(NGRP); k++) begin
      c = cg2_q[k];
      for (int j = 0; j < int'(GROUP); j++) begin
        sum[k*GROUP+j] = p2_q[k*GROUP+j] ^ c;
        c = g2_q[k*GROUP+j] | (p2_q[k*GROUP+j] & c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      p1_q     <= '0;
      g1_q     <= '0;
      c0_1_q   <= 1'b0;
      a_msb1_q <= 1'b0;
      b_msb1_q <= 1'b0;
      v2_q     <= 1'b0;
      p2_q     <= '0;
      g2_q     <= '0;
      cg2_q    <= '0;
      a_msb2_q <= 1'b0;
      b_msb2_q <= 1'b0;
      v3_q     <= 1'b0;
      s_q      <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (en) begin
      v1_q     <= in_valid;
      p1_q     <= a ^ b_eff;
      g1_q     <= a & b_eff;
      c0_1_q   <= c0;
      a_msb1_q <= a[WIDTH-1];
      b_msb1_q <= b_eff[WIDTH-1];

      v2_q     <= v1_q;
      p2_q     <= p1_q;
      g2_q     <= g1_q;
      cg2_q    <= cg;
      a_msb2_q <= a_msb1_q;
      b_msb2_q <= b_msb1_q;

      v3_q     <= v2_q;
      s_q      <= sum;
      c_out_q  <= cg2_q[NGRP];
      // Same-sign operands producing an opposite-sign result; equals carry-in ^ carry-out
      // of the MSB.
      ovf_q    <= ~(a_msb2_q ^ b_msb2_q) & (sum[WIDTH-1] ^ a_msb2_q);
      zero_q   <= ~|sum;
    end
  end

  assign out_valid = v3_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   lat_en = 1'b1;
  bit   drv_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model using wide unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tsub, input logic tcin);
    exp_t e;
    logic [W:0] full;
    int sa, sbv, r;
    if (!tsub) full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
    else       full = {1'b0, ta} + {1'b0, ~tb} + {{W{1'b0}}, ~tcin};
    sa  = int'($signed(ta));
    sbv = int'($signed(tb));
    r   = tsub ? (sa - sbv - int'(tcin)) : (sa + sbv + int'(tcin));
    e.s   = full[W-1:0];
    e.c   = full[W];
    e.v   = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    e.z   = (full[W-1:0] == '0);
    e.cyc = 0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tsub, input logic tcin);
    exp_t e;
    int n = 0;
    a = ta; b = tb; sub = tsub; c_in = tcin; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      e = model(ta, tb, tsub, tcin);
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    bit stall_prev = 1'b0;
    logic [W-1:0] s_prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && stall_prev) check_eq("hold_s", 32'(s), 32'(s_prev));
        if (out_valid && !out_ready) check_eq("in_ready_stall", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("s", 32'(s), 32'(e.s));
            check_eq("c_out", 32'(c_out), 32'(e.c));
            check_eq("ovf", 32'(ovf), 32'(e.v));
            check_eq("zero", 32'(zero), 32'(e.z));
            if (lat_en) check_eq("latency", cyc - e.cyc, 32'd3);
          end
        end
        stall_prev = out_valid && !out_ready;
        s_prev     = s;
      end else begin
        stall_prev = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_s", 32'(s), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_flags", {29'd0, c_out, ovf, zero}, 32'd0);
    @(posedge clk);
    #1;

    // Directed single beats with full latency checking
    send(16'h1234, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // Backpressure on back-to-back beats
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 16'(i), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Random operands with random consumer stalls
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;

    // Reset mid-flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b1, 1'b0);
    send(16'h4444, 16'h0004, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_s", 32'(s), 32'd0);
    #4;
    sb.delete();
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lat_en = 1'b1;
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
